// File: rtl/calc_pkg.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Package   : calc_pkg                                                       |
// | Purpose   : Shared opcode constants and sequencer state encoding for the   |
// |             calculator entry sequencer and its environment.                |
// | Revision  : 1.0  initial release                                           |
// +----------------------------------------------------------------------------+
package calc_pkg;

  localparam int OP_W = 3;

  // Calculator opcodes. For the ABS opcodes bit 0 is a don't-care:
  // 3'b01? selects |B| and 3'b11? selects |A|.
  localparam logic [OP_W-1:0] OP_ADD_AB = 3'b000;
  localparam logic [OP_W-1:0] OP_SUB_AB = 3'b001;
  localparam logic [OP_W-1:0] OP_ABS_B  = 3'b010;
  localparam logic [OP_W-1:0] OP_ADD_BA = 3'b100;
  localparam logic [OP_W-1:0] OP_SUB_BA = 3'b101;
  localparam logic [OP_W-1:0] OP_ABS_A  = 3'b110;

  typedef enum logic [2:0] {
    S_A    = 3'd0,
    S_B    = 3'd1,
    S_OP   = 3'd2,
    S_EXEC = 3'd3,
    S_HOLD = 3'd4
  } calc_state_e;

endpackage : calc_pkg
`default_nettype wire

// File: rtl/calc_sat_cnt.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module    : calc_sat_cnt                                                   |
// | Purpose   : CW-bit saturating event counter with synchronous clear.        |
// |             Holds at all-ones instead of wrapping.                         |
// | Ports     : clk   - rising-edge clock                                      |
// |             reset - synchronous active-high clear                          |
// |             inc   - count one event this cycle                             |
// |             cnt   - current count                                          |
// | Revision  : 1.0  initial release                                           |
// +----------------------------------------------------------------------------+
module calc_sat_cnt #(
  parameter int CW = 8
) (
  input  logic          clk,
  input  logic          reset,
  input  logic          inc,
  output logic [CW-1:0] cnt
);

  logic [CW-1:0] cnt_q;
  logic [CW-1:0] cnt_d;

  always_comb begin
    cnt_d = cnt_q;
    if (inc && (cnt_q != {CW{1'b1}})) begin
      cnt_d = cnt_q + CW'(1);
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

  assign cnt = cnt_q;

endmodule : calc_sat_cnt
`default_nettype wire

// File: rtl/calc_entry_seq.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module    : calc_entry_seq                                                 |
// | Purpose   : Upstream sequencer for a combinational W-bit calculator.       |
// |             Collects A, B and opcode as three words on one valid/ready     |
// |             stream, drives them as stable registered operands, captures    |
// |             the result one cycle later and offers it on a valid/ready      |
// |             result stream. Counts overflowed results (saturating).         |
// | Ports     : clk, reset            - clock, sync active-high reset          |
// |             din/din_valid/din_ready - entry stream (A, B, opcode)          |
// |             chain_clr             - force full entry for next op           |
// |             calc_a/calc_b/calc_op - operands to the calculator             |
// |             calc_r/calc_ovf       - calculator result                      |
// |             res/res_ovf/res_valid/res_ready - result stream                |
// |             ovf_cnt               - saturating overflow count              |
// | Config    : CALC_CHAIN_EN - when defined, an accepted non-overflow result  |
// |             is fed back as A and the A entry is skipped (unless chain_clr).|
// | Revision  : 1.0  initial release                                           |
// +----------------------------------------------------------------------------+
module calc_entry_seq
  import calc_pkg::*;
#(
  parameter int W  = 16,
  parameter int CW = 8
) (
  input  logic          clk,
  input  logic          reset,
  input  logic [W-1:0]  din,
  input  logic          din_valid,
  output logic          din_ready,
  input  logic          chain_clr,
  output logic [W-1:0]  calc_a,
  output logic [W-1:0]  calc_b,
  output logic [2:0]    calc_op,
  input  logic [W-1:0]  calc_r,
  input  logic          calc_ovf,
  output logic [W-1:0]  res,
  output logic          res_ovf,
  output logic          res_valid,
  input  logic          res_ready,
  output logic [CW-1:0] ovf_cnt
);

  calc_state_e   state_q, state_d;
  logic [W-1:0]  a_q, a_d;
  logic [W-1:0]  b_q, b_d;
  logic [2:0]    op_q, op_d;
  logic [W-1:0]  res_q, res_d;
  logic          res_ovf_q, res_ovf_d;
  logic          res_valid_q, res_valid_d;

  always_comb begin
    state_d     = state_q;
    a_d         = a_q;
    b_d         = b_q;
    op_d        = op_q;
    res_d       = res_q;
    res_ovf_d   = res_ovf_q;
    res_valid_d = res_valid_q;
    din_ready   = 1'b0;

    case (state_q)
      S_A: begin
        din_ready = 1'b1;
        if (din_valid) begin
          a_d     = din;
          state_d = S_B;
        end
      end
      S_B: begin
        din_ready = 1'b1;
        if (din_valid) begin
          b_d     = din;
          state_d = S_OP;
        end
      end
      S_OP: begin
        din_ready = 1'b1;
        if (din_valid) begin
          op_d    = din[2:0];
          state_d = S_EXEC;
        end
      end
      S_EXEC: begin
        // Operands have been stable for a full cycle, so calc_r/calc_ovf
        // have settled through the calculator.
        res_d       = calc_r;
        res_ovf_d   = calc_ovf;
        res_valid_d = 1'b1;
        state_d     = S_HOLD;
      end
      S_HOLD: begin
        if (res_valid_q && res_ready) begin
          res_valid_d = 1'b0;
          state_d     = S_A;
`ifdef CALC_CHAIN_EN
          // Accumulator-style chaining: a clean result becomes the next A.
          if (!res_ovf_q && !chain_clr) begin
            a_d     = res_q;
            state_d = S_B;
          end
`endif
        end
      end
      default: begin
        state_d = S_A;
      end
    endcase
  end

`ifndef CALC_CHAIN_EN
  // Without chaining the chain_clr input has no function.
  logic unused_chain_clr;
  assign unused_chain_clr = chain_clr;
`endif

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q     <= S_A;
      a_q         <= '0;
      b_q         <= '0;
      op_q        <= '0;
      res_q       <= '0;
      res_ovf_q   <= 1'b0;
      res_valid_q <= 1'b0;
    end else begin
      state_q     <= state_d;
      a_q         <= a_d;
      b_q         <= b_d;
      op_q        <= op_d;
      res_q       <= res_d;
      res_ovf_q   <= res_ovf_d;
      res_valid_q <= res_valid_d;
    end
  end

  calc_sat_cnt #(
    .CW (CW)
  ) u_ovf_cnt (
    .clk   (clk),
    .reset (reset),
    .inc   ((state_q == S_EXEC) && calc_ovf),
    .cnt   (ovf_cnt)
  );

  assign calc_a    = a_q;
  assign calc_b    = b_q;
  assign calc_op   = op_q;
  assign res       = res_q;
  assign res_ovf   = res_ovf_q;
  assign res_valid = res_valid_q;

endmodule : calc_entry_seq
`default_nettype wire

// File: tb/tb_calc_entry_seq.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module    : tb_calc_entry_seq                                              |
// | Purpose   : Self-checking bench for calc_entry_seq with a behavioural      |
// |             16-bit calculator wired to the calc_* ports. Results are       |
// |             checked against a scoreboard of hand-derived expectations.     |
// | Config    : CALC_CHAIN_EN - enables the chaining sequence.                 |
// | Revision  : 1.0  initial release                                           |
// +----------------------------------------------------------------------------+
module tb_calc_entry_seq;

  localparam int W  = 16;
  localparam int CW = 8;

  logic          clk = 1'b0;
  logic          reset;
  logic [W-1:0]  din;
  logic          din_valid;
  logic          din_ready;
  logic          chain_clr;
  logic [W-1:0]  calc_a, calc_b, calc_r;
  logic [2:0]    calc_op;
  logic          calc_ovf;
  logic [W-1:0]  res;
  logic          res_ovf, res_valid, res_ready;
  logic [CW-1:0] ovf_cnt;

  int n_chk  = 0;
  int n_fail = 0;

  typedef struct {
    logic [W-1:0] r;
    logic         ovf;
  } exp_t;
  exp_t sb[$];

  typedef struct {
    logic [W-1:0] a;
    logic [W-1:0] b;
    logic [2:0]   op;
    logic [W-1:0] exp_r;
    logic         exp_ovf;
  } vec_t;
  vec_t vecs[9];

  always #5 clk = ~clk;

  calc_entry_seq #(.W(W), .CW(CW)) dut (
    .clk       (clk),
    .reset     (reset),
    .din       (din),
    .din_valid (din_valid),
    .din_ready (din_ready),
    .chain_clr (chain_clr),
    .calc_a    (calc_a),
    .calc_b    (calc_b),
    .calc_op   (calc_op),
    .calc_r    (calc_r),
    .calc_ovf  (calc_ovf),
    .res       (res),
    .res_ovf   (res_ovf),
    .res_valid (res_valid),
    .res_ready (res_ready),
    .ovf_cnt   (ovf_cnt)
  );

  // Behavioural two's-complement calculator.
  always_comb begin
    calc_r   = '0;
    calc_ovf = 1'b0;
    casez (calc_op)
      3'b000, 3'b100: begin
        calc_r   = calc_a + calc_b;
        calc_ovf = (calc_a[15] == calc_b[15]) && (calc_r[15] != calc_a[15]);
      end
      3'b001: begin
        calc_r   = calc_a - calc_b;
        calc_ovf = (calc_a[15] != calc_b[15]) && (calc_r[15] != calc_a[15]);
      end
      3'b101: begin
        calc_r   = calc_b - calc_a;
        calc_ovf = (calc_b[15] != calc_a[15]) && (calc_r[15] != calc_b[15]);
      end
      3'b01?: begin
        calc_r   = calc_b[15] ? (16'h0 - calc_b) : calc_b;
        calc_ovf = (calc_b == 16'h8000);
      end
      default: begin
        calc_r   = calc_a[15] ? (16'h0 - calc_a) : calc_a;
        calc_ovf = (calc_a == 16'h8000);
      end
    endcase
  end

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic timeout(input string name);
    n_chk++;
    n_fail++;
    $display("FAIL %s: timed out at %0t", name, $time);
  endtask

  // Result monitor: compare on every handshake cycle, away from the edge.
  always @(negedge clk) begin
    if (!reset && res_valid && res_ready) begin
      if (sb.size() == 0) begin
        timeout("unexpected_result");
      end else begin
        exp_t e;
        e = sb.pop_front();
        chk("res", res, e.r);
        chk("res_ovf", res_ovf, e.ovf);
      end
    end
  end

  task automatic send_word(input logic [W-1:0] w);
    logic rdy;
    int   n;
    n = 0;
    din       = w;
    din_valid = 1'b1;
    rdy       = din_ready;
    @(posedge clk); #1;
    while (!rdy) begin
      n++;
      if (n > 20) begin
        timeout("send_word");
        break;
      end
      rdy = din_ready;
      @(posedge clk); #1;
    end
    din_valid = 1'b0;
  endtask

  task automatic run_op(input logic [W-1:0] a, input logic [W-1:0] b, input logic [2:0] op,
                        input logic [W-1:0] er, input logic eo);
    exp_t e;
    send_word(a);
    send_word(b);
    e.r   = er;
    e.ovf = eo;
    sb.push_back(e);
    send_word({13'h0, op});
  endtask

  task automatic wait_ready();
    int n;
    n = 0;
    while (!din_ready) begin
      n++;
      if (n > 50) begin
        timeout("wait_ready");
        break;
      end
      @(posedge clk); #1;
    end
  endtask

  task automatic wait_valid();
    int n;
    n = 0;
    while (!res_valid) begin
      n++;
      if (n > 50) begin
        timeout("wait_valid");
        break;
      end
      @(posedge clk); #1;
    end
  endtask

  initial begin
    vecs[0] = '{16'h8000, 16'h1234, 3'b111, 16'h8000, 1'b1};
    vecs[1] = '{16'hFFFB, 16'h9999, 3'b111, 16'h0005, 1'b0};
    vecs[2] = '{16'hFFFB, 16'h0000, 3'b110, 16'h0005, 1'b0};
    vecs[3] = '{16'h1234, 16'hFFF0, 3'b010, 16'h0010, 1'b0};
    vecs[4] = '{16'h0003, 16'h000A, 3'b101, 16'h0007, 1'b0};
    vecs[5] = '{16'h8000, 16'h0001, 3'b100, 16'h8001, 1'b0};
    vecs[6] = '{16'h8000, 16'h0001, 3'b101, 16'h8001, 1'b1};
    vecs[7] = '{16'h7FFF, 16'hFFFF, 3'b001, 16'h8000, 1'b1};
    vecs[8] = '{16'h0064, 16'h8000, 3'b011, 16'h8000, 1'b1};

    reset     = 1'b1;
    din       = '0;
    din_valid = 1'b0;
    chain_clr = 1'b1;
    res_ready = 1'b1;
    repeat (3) @(posedge clk);
    #1 reset = 1'b0;

    // Reset state
    chk("rst_din_ready", din_ready, 1);
    chk("rst_res_valid", res_valid, 0);
    chk("rst_res", res, 0);
    chk("rst_ovf_cnt", ovf_cnt, 0);
    chk("rst_calc_a", calc_a, 0);
    chk("rst_calc_op", calc_op, 0);

    // 5 - 3: latency, result visible two cycles after the opcode cycle
    run_op(16'd5, 16'd3, 3'b001, 16'h0002, 1'b0);
    chk("lat_exec_valid", res_valid, 0);
    chk("lat_exec_din_ready", din_ready, 0);
    @(posedge clk); #1;
    chk("lat_valid", res_valid, 1);
    chk("lat_res", res, 16'h0002);
    @(posedge clk); #1;
    chk("lat_din_ready_after", din_ready, 1);
    chk("lat_valid_after", res_valid, 0);

    // 0x7FFF + 1 with back-pressure
    res_ready = 1'b0;
    run_op(16'h7FFF, 16'h0001, 3'b000, 16'h8000, 1'b1);
    wait_valid();
    chk("hold_ovf_cnt", ovf_cnt, 1);
    for (int i = 0; i < 5; i++) begin
      chk("hold_res", res, 16'h8000);
      chk("hold_res_valid", res_valid, 1);
      chk("hold_din_ready", din_ready, 0);
      chk("hold_calc_a", calc_a, 16'h7FFF);
      @(posedge clk); #1;
    end
    res_ready = 1'b1;
    wait_ready();

    // Table of opcode / operand patterns
    for (int i = 0; i < 9; i++) begin
      run_op(vecs[i].a, vecs[i].b, vecs[i].op, vecs[i].exp_r, vecs[i].exp_ovf);
      chk("tbl_calc_b", calc_b, vecs[i].b);
      chk("tbl_calc_op", calc_op, vecs[i].op);
      wait_ready();
    end
    chk("tbl_ovf_cnt", ovf_cnt, 5);

    // din_valid idle every other cycle: idle words must not load
    begin
      exp_t e;
      din = 16'hDEAD; din_valid = 1'b0; @(posedge clk); #1;
      send_word(16'h0010);
      din = 16'hBEEF; din_valid = 1'b0; @(posedge clk); #1;
      chk("gap_calc_a", calc_a, 16'h0010);
      send_word(16'h0020);
      din = 16'h0007; din_valid = 1'b0; @(posedge clk); #1;
      chk("gap_calc_b", calc_b, 16'h0020);
      e.r = 16'h0030; e.ovf = 1'b0;
      sb.push_back(e);
      send_word(16'h0000);
      wait_ready();
    end

    // Reset while a result is pending in S_HOLD
    res_ready = 1'b0;
    run_op(16'h0100, 16'h0001, 3'b001, 16'h00FF, 1'b0);
    wait_valid();
    reset = 1'b1;
    @(posedge clk); #1;
    reset = 1'b0;
    sb.delete();
    chk("rsthold_res_valid", res_valid, 0);
    chk("rsthold_din_ready", din_ready, 1);
    chk("rsthold_ovf_cnt", ovf_cnt, 0);
    chk("rsthold_calc_a", calc_a, 0);
    res_ready = 1'b1;

`ifdef CALC_CHAIN_EN
    // Chaining: 2+3=5, then B=4 only -> 9; chain_clr forces a full entry
    chain_clr = 1'b0;
    run_op(16'd2, 16'd3, 3'b000, 16'd5, 1'b0);
    wait_ready();
    chk("chain_calc_a", calc_a, 16'd5);
    begin
      exp_t e;
      send_word(16'd4);
      e.r = 16'd9; e.ovf = 1'b0;
      sb.push_back(e);
      chain_clr = 1'b1;
      send_word(16'd0);
      wait_ready();
    end
    run_op(16'd7, 16'd1, 3'b000, 16'd8, 1'b0);
    wait_ready();
`else
    // chain_clr low has no effect: the next op still needs its A word
    chain_clr = 1'b0;
    run_op(16'd2, 16'd3, 3'b000, 16'd5, 1'b0);
    wait_ready();
    run_op(16'd7, 16'd1, 3'b000, 16'd8, 1'b0);
    wait_ready();
    chain_clr = 1'b1;
`endif

    // Counter saturation over 300 overflowing results
    for (int i = 1; i <= 300; i++) begin
      run_op(16'h7FFF, 16'h0001, 3'b000, 16'h8000, 1'b1);
      wait_ready();
      if (i == 254) chk("sat_cnt_254", ovf_cnt, 254);
      if (i == 255) chk("sat_cnt_255", ovf_cnt, 255);
      if (i == 300) chk("sat_cnt_300", ovf_cnt, 255);
    end

    repeat (2) @(posedge clk); #1;
    chk("sb_drained", sb.size(), 0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule : tb_calc_entry_seq
`default_nettype wire
